evaluador_condiciones: RTL and testbench

EVALUADOR_CONDICIONES -- requirements
Module: evaluador_condiciones

---
 rtl/evaluador_condiciones.sv | 145 ++++++++++++++
 tb/tb_evaluador_condiciones.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evaluador_condiciones.sv
// Condition-code evaluator with a flag register and a small flag save stack.
// A request (cond_valid/cond_ready) is evaluated against the current flags,
// or against flags_in when flags_we forwards a write. The result is held in
// a one-entry output register (salto_valid/salto_ready).
module evaluador_condiciones #(
  parameter int unsigned PROFUNDIDAD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] flags_in,
  input  logic       flags_we,
  input  logic       flags_push,
  input  logic       flags_pop,
  input  logic [3:0] cond,
  input  logic       cond_valid,
  output logic       cond_ready,
  output logic       salto_valid,
  input  logic       salto_ready,
  output logic       salto_tomado,
  output logic [3:0] flags_reg,
  output logic       pila_vacia,
  output logic       pila_llena,
  output logic       error_pila
);

  localparam int unsigned OccW = $clog2(PROFUNDIDAD + 1);
  localparam int unsigned IdxW = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;
  localparam logic [OccW-1:0] OccLleno = OccW'(PROFUNDIDAD);

  logic [3:0]      flags_q, flags_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            error_q, error_d;
  logic            valid_q, valid_d;
  logic            tomado_q, tomado_d;
  logic [3:0]      pila_q [PROFUNDIDAD];

  logic [3:0]      operando;
  logic            resultado;
  logic            aceptar;
  logic            vacia, llena;
  logic            push_ok, pop_ok, mal_uso;
  logic [IdxW-1:0] push_idx, pop_idx;

  assign vacia    = (occ_q == '0);
  assign llena    = (occ_q == OccLleno);
  assign push_idx = IdxW'(occ_q);
  assign pop_idx  = IdxW'(occ_q - OccW'(1));

  // Stack operation qualification; simultaneous push and pop is misuse.
  always_comb begin
    push_ok = flags_push & ~flags_pop & ~llena;
    pop_ok  = flags_pop & ~flags_push & ~vacia;
    mal_uso = (flags_push & flags_pop) | (flags_push & llena) | (flags_pop & vacia);
  end

  // Condition evaluation on the forwarded operand {C, V, Z, N}.
  always_comb begin
    operando  = flags_we ? flags_in : flags_q;
    resultado = 1'b0;
    case (cond)
      4'd0:  resultado = operando[1];
      4'd1:  resultado = ~operando[1];
      4'd2:  resultado = operando[3];
      4'd3:  resultado = ~operando[3];
      4'd4:  resultado = operando[0];
      4'd5:  resultado = ~operando[0];
      4'd6:  resultado = operando[2];
      4'd7:  resultado = ~operando[2];
      4'd8:  resultado = operando[3] & ~operando[1];
      4'd9:  resultado = ~operando[3] | operando[1];
      4'd10: resultado = (operando[0] == operando[2]);
      4'd11: resultado = (operando[0] != operando[2]);
      4'd12: resultado = ~operando[1] & (operando[0] == operando[2]);
      4'd13: resultado = operando[1] | (operando[0] != operando[2]);
      4'd14: resultado = 1'b1;
      4'd15: resultado = 1'b0;
      default: resultado = 1'b0;
    endcase
  end

  // Handshake: a new request can enter whenever the output slot frees up this cycle.
  always_comb begin
    cond_ready = ~valid_q | salto_ready;
    aceptar    = cond_valid & cond_ready;
  end

  // Next-state for result register, flag register, occupancy and sticky error.
  always_comb begin
    valid_d  = valid_q;
    tomado_d = tomado_q;
    if (aceptar) begin
      valid_d  = 1'b1;
      tomado_d = resultado;
    end else if (salto_ready) begin
      valid_d  = 1'b0;
    end

    flags_d = flags_q;
    occ_d   = occ_q;
    if (push_ok) begin
      occ_d = occ_q + OccW'(1);
    end else if (pop_ok) begin
      occ_d   = occ_q - OccW'(1);
      flags_d = pila_q[pop_idx];
    end
    // A write always wins, even over a restored entry.
    if (flags_we) begin
      flags_d = flags_in;
    end

    error_d = error_q | mal_uso;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= 4'b0000;
      occ_q    <= '0;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
      tomado_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      occ_q    <= occ_d;
      error_q  <= error_d;
      valid_q  <= valid_d;
      tomado_q <= tomado_d;
    end
  end

  // Stack storage needs no reset: entries are only read below the occupancy.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pila_q[push_idx] <= flags_q;
    end
  end

  assign salto_valid  = valid_q;
  assign salto_tomado = tomado_q;
  assign flags_reg    = flags_q;
  assign pila_vacia   = vacia;
  assign pila_llena   = llena;
  assign error_pila   = error_q;

endmodule

// File: tb/tb_evaluador_condiciones.sv
// Bench for evaluador_condiciones: condition table, hand sequences for the
// handshake and stack corners, then random traffic against a queue-based model.
module tb_evaluador_condiciones;

  localparam int PROF = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] flags_in;
  logic       flags_we;
  logic       flags_push;
  logic       flags_pop;
  logic [3:0] cond;
  logic       cond_valid;
  logic       cond_ready;
  logic       salto_valid;
  logic       salto_ready;
  logic       salto_tomado;
  logic [3:0] flags_reg;
  logic       pila_vacia;
  logic       pila_llena;
  logic       error_pila;

  evaluador_condiciones #(.PROFUNDIDAD(PROF)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flags_in     (flags_in),
    .flags_we     (flags_we),
    .flags_push   (flags_push),
    .flags_pop    (flags_pop),
    .cond         (cond),
    .cond_valid   (cond_valid),
    .cond_ready   (cond_ready),
    .salto_valid  (salto_valid),
    .salto_ready  (salto_ready),
    .salto_tomado (salto_tomado),
    .flags_reg    (flags_reg),
    .pila_vacia   (pila_vacia),
    .pila_llena   (pila_llena),
    .error_pila   (error_pila)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [3:0] m_flags;
  logic [3:0] m_pila[$];
  logic       m_err;
  logic       m_valid;
  logic       m_tom;

  typedef struct packed {
    logic [3:0] f;
    logic [3:0] c;
    logic       e;
  } vec_t;
  vec_t tabla[18];

  task automatic chk1(input string nombre, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nombre, act, exp, $time);
    end
  endtask

  task automatic chk4(input string nombre, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nombre, act, exp, $time);
    end
  endtask

  // Conditions come in true/false pairs; the odd code is the complement.
  function automatic logic ref_eval(input logic [3:0] f, input logic [3:0] c);
    logic cc, vv, zz, nn, base;
    cc = f[3]; vv = f[2]; zz = f[1]; nn = f[0];
    case (c[3:1])
      3'd0: base = zz;
      3'd1: base = cc;
      3'd2: base = nn;
      3'd3: base = vv;
      3'd4: base = cc && !zz;
      3'd5: base = (nn == vv);
      3'd6: base = !zz && (nn == vv);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic idle();
    flags_in = 4'b0000; flags_we = 1'b0; flags_push = 1'b0; flags_pop = 1'b0;
    cond = 4'd0; cond_valid = 1'b0; salto_ready = 1'b1;
  endtask

  task automatic check_model();
    chk4("flags_reg", flags_reg, m_flags);
    chk1("pila_vacia", pila_vacia, m_pila.size() == 0);
    chk1("pila_llena", pila_llena, m_pila.size() == PROF);
    chk1("error_pila", error_pila, m_err);
    chk1("salto_valid", salto_valid, m_valid);
    if (m_valid) chk1("salto_tomado", salto_tomado, m_tom);
  endtask

  // One clock with the inputs currently driven; model advances in step.
  task automatic ciclo();
    logic       acc, full, empty;
    logic [3:0] op, tmp;
    #1;
    chk1("cond_ready", cond_ready, !m_valid || salto_ready);
    acc   = cond_valid && (!m_valid || salto_ready);
    op    = flags_we ? flags_in : m_flags;
    full  = (m_pila.size() == PROF);
    empty = (m_pila.size() == 0);
    @(posedge clk);
    #1;
    if (acc) begin
      m_valid = 1'b1;
      m_tom   = ref_eval(op, cond);
    end else if (salto_ready) begin
      m_valid = 1'b0;
    end
    if ((flags_push && flags_pop) || (flags_push && full) || (flags_pop && empty)) begin
      m_err = 1'b1;
    end else if (flags_push) begin
      m_pila.push_back(m_flags);
    end else if (flags_pop) begin
      tmp = m_pila.pop_back();
      if (!flags_we) m_flags = tmp;
    end
    if (flags_we) m_flags = flags_in;
    check_model();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    idle();
    m_flags = 4'b0000; m_pila.delete(); m_err = 1'b0; m_valid = 1'b0; m_tom = 1'b0;
    #2;
    chk4("rst_flags", flags_reg, 4'b0000);
    chk1("rst_vacia", pila_vacia, 1'b1);
    chk1("rst_llena", pila_llena, 1'b0);
    chk1("rst_error", error_pila, 1'b0);
    chk1("rst_valid", salto_valid, 1'b0);
    chk1("rst_tomado", salto_tomado, 1'b0);
    chk1("rst_ready", cond_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tabla[0]  = '{4'b0010, 4'd0,  1'b1};
    tabla[1]  = '{4'b0000, 4'd1,  1'b1};
    tabla[2]  = '{4'b1000, 4'd2,  1'b1};
    tabla[3]  = '{4'b1000, 4'd3,  1'b0};
    tabla[4]  = '{4'b0001, 4'd4,  1'b1};
    tabla[5]  = '{4'b0001, 4'd5,  1'b0};
    tabla[6]  = '{4'b0100, 4'd6,  1'b1};
    tabla[7]  = '{4'b0000, 4'd7,  1'b1};
    tabla[8]  = '{4'b1000, 4'd8,  1'b1};
    tabla[9]  = '{4'b1010, 4'd8,  1'b0};
    tabla[10] = '{4'b1010, 4'd9,  1'b1};
    tabla[11] = '{4'b0101, 4'd10, 1'b1};
    tabla[12] = '{4'b0100, 4'd11, 1'b1};
    tabla[13] = '{4'b0000, 4'd12, 1'b1};
    tabla[14] = '{4'b0010, 4'd12, 1'b0};
    tabla[15] = '{4'b0001, 4'd13, 1'b1};
    tabla[16] = '{4'b0000, 4'd14, 1'b1};
    tabla[17] = '{4'b1111, 4'd15, 1'b0};
    reset_dut();

    // Condition table, operand forwarded from flags_in in the accepting cycle
    for (int i = 0; i < 18; i++) begin
      flags_in = tabla[i].f; flags_we = 1'b1; cond = tabla[i].c; cond_valid = 1'b1;
      ciclo();
      chk1("tabla_valid", salto_valid, 1'b1);
      chk1("tabla_tomado", salto_tomado, tabla[i].e);
      chk4("tabla_flags", flags_reg, tabla[i].f);
    end
    idle();
    ciclo();

    // Back-to-back GE then LT with flags 0101
    flags_in = 4'b0101; flags_we = 1'b1;
    ciclo();
    idle();
    cond = 4'd10; cond_valid = 1'b1;
    ciclo();
    chk1("b2b_ge", salto_tomado, 1'b1);
    cond = 4'd11;
    #1;
    chk1("b2b_ready", cond_ready, 1'b1);
    ciclo();
    chk1("b2b_lt", salto_tomado, 1'b0);
    chk1("b2b_valid", salto_valid, 1'b1);

    // Backpressure: result held for 3 cycles, new request waits
    cond = 4'd14;
    ciclo();
    cond = 4'd15; salto_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("bp_ready", cond_ready, 1'b0);
      ciclo();
      chk1("bp_tomado", salto_tomado, 1'b1);
      chk1("bp_valid", salto_valid, 1'b1);
    end
    salto_ready = 1'b1;
    #1;
    chk1("bp_release_ready", cond_ready, 1'b1);
    ciclo();
    chk1("bp_new", salto_tomado, 1'b0);
    idle();
    ciclo();
    chk1("bp_drain", salto_valid, 1'b0);

    // Fill, overflow, and drain the stack
    reset_dut();
    flags_in = 4'b1000; flags_we = 1'b1;
    ciclo();
    flags_push = 1'b1;
    flags_in = 4'b0100; ciclo();
    flags_in = 4'b0010; ciclo();
    flags_in = 4'b0001; ciclo();
    flags_we = 1'b0;
    ciclo();
    chk1("pila_llena_4", pila_llena, 1'b1);
    chk1("pila_err_pre", error_pila, 1'b0);
    ciclo();
    chk1("pila_err_over", error_pila, 1'b1);
    chk1("pila_llena_over", pila_llena, 1'b1);
    flags_push = 1'b0; flags_pop = 1'b1;
    ciclo(); chk4("pop1", flags_reg, 4'b0001);
    ciclo(); chk4("pop2", flags_reg, 4'b0010);
    ciclo(); chk4("pop3", flags_reg, 4'b0100);
    ciclo(); chk4("pop4", flags_reg, 4'b1000);
    chk1("pop_vacia", pila_vacia, 1'b1);
    idle();

    // Pop on empty, sticky error
    reset_dut();
    flags_in = 4'b1010; flags_we = 1'b1;
    ciclo();
    idle();
    flags_pop = 1'b1;
    ciclo();
    chk4("underflow_flags", flags_reg, 4'b1010);
    chk1("underflow_err", error_pila, 1'b1);
    idle();
    for (int i = 0; i < 3; i++) ciclo();
    chk1("err_sticky", error_pila, 1'b1);

    // Asynchronous reset mid-transaction
    reset_dut();
    flags_in = 4'b0110; flags_we = 1'b1; flags_push = 1'b1;
    ciclo();
    flags_we = 1'b0;
    ciclo();
    flags_push = 1'b0; cond = 4'd14; cond_valid = 1'b1; salto_ready = 1'b0;
    ciclo();
    cond_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk1("async_valid", salto_valid, 1'b0);
    chk1("async_vacia", pila_vacia, 1'b1);
    chk4("async_flags", flags_reg, 4'b0000);
    chk1("async_ready", cond_ready, 1'b1);
    reset_dut();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      flags_in    = 4'($urandom_range(0, 15));
      flags_we    = ($urandom_range(0, 1) == 1);
      flags_push  = ($urandom_range(0, 3) == 0);
      flags_pop   = ($urandom_range(0, 3) == 0);
      cond        = 4'($urandom_range(0, 15));
      cond_valid  = ($urandom_range(0, 9) < 7);
      salto_ready = ($urandom_range(0, 9) < 7);
      ciclo();
      if (i % 150 == 149) reset_dut();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
